binary_to_bcd_seq: RTL and testbench
====================================

# binary_to_bcd_seq

Parametrised, sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one input bit per clock. It is the successor to the 4-bit combinational converter: arbitrary input width, valid/ready handshakes on both sides, and an optional signed mode. It sits between binary datapath results and display or serial-print logic.

## Interface
- BIN_W, 8, binary input width (≥ 2)
- DIGITS, 3, number of BCD output digits; elaboration error unless 10**DIGITS > 2**BIN_W − 1
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  bin is valid
- in_ready  output  1  converter idle, can accept
- bin  input  BIN_W  binary value
- out_valid  output  1  bcd/neg valid
- out_ready  input  1  consumer accepts result
- bcd  output  4*DIGITS  packed BCD, digit 0 in [3:0]
- neg  output  1  result negative (signed mode only)

Clock is `clk`. Reset is `rst`, synchronous and active-high.

## Operation
- FSM states IDLE, SHIFT, DONE; reset → IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - load shift register with bin, or |bin| in signed mode;
  - clear BCD accumulator;
  - bit counter = BIN_W−1;
  - go to SHIFT.
- SHIFT, each cycle:
  - every 4-bit digit ≥ 5 gets +3;
  - then shift {accumulator, shift register} left one bit, MSB of binary entering digit 0 LSB;
  - when counter reaches 0, go to DONE; otherwise decrement.
- DONE: out_valid=1, bcd/neg held stable. On out_ready, go to IDLE.
- in_ready is 0 in SHIFT and DONE. No input queueing; in_valid outside IDLE is ignored.
- Digit adjust uses 4-bit unsigned arithmetic per digit. No carry between digits: the adjust never overflows a digit.
- Unused upper digits (when 4*DIGITS exceeds what BIN_W needs) are 0.

## Timing
- Reset values: in_ready=0 during the reset cycle and 1 afterwards; out_valid=0, bcd=0, neg=0.
- Latency: out_valid rises exactly BIN_W cycles after the accepting edge.
- Throughput with out_ready held high: one result per BIN_W+2 cycles (accept, BIN_W shifts, DONE).
- out_valid with out_ready=0: result is held indefinitely, unchanged.
- bcd/neg are registered and change only on entry to DONE or on reset.
- Reset mid-SHIFT or mid-DONE: the conversion is dropped, the FSM returns to IDLE, and outputs are cleared the next cycle.
- Simultaneous rst with in_valid: reset wins; nothing is accepted.

## Configuration
- BTOBCD_SIGNED_EN defined:
  - bin is two's complement;
  - neg = bin[BIN_W−1] captured at accept;
  - magnitude is converted;
  - most negative input −2**(BIN_W−1) gives neg=1 and magnitude 2**(BIN_W−1).
- Not defined:
  - bin is unsigned;
  - neg tied 0.
- The port list is identical in both builds.

## Structure
- Package btobcd_pkg holds:
  - state enum (IDLE, SHIFT, DONE);
  - BCD_DIGIT_W = 4;
  - function min_digits(bin_w), used for the DIGITS elaboration check.
- Sub-module bcd_digit_adj: combinational, one 4-bit digit in, +3 if ≥ 5, instantiated DIGITS times by generate.
- Bit counter width is $clog2(BIN_W).

## Test plan
- BIN_W=4, DIGITS=2, unsigned: bin=0..15 sequentially (including 15 → BCD 8'b0001_0101, then wrap to 0) → each result correct, out_valid exactly 4 cycles after accept.
- BIN_W=8, DIGITS=3: bin=255 → bcd=12'h255; bin=0 → 12'h000; bin=100 → 12'h100.
- Backpressure: out_ready=0 for 10 cycles after out_valid → bcd stable, in_ready=0, a second in_valid is ignored; out_ready=1 → IDLE, next input accepted.
- Reset at the 3rd SHIFT cycle of bin=200 → next cycle out_valid=0, bcd=0, in_ready=1; a fresh bin=42 then yields 12'h042.
- BTOBCD_SIGNED_EN, BIN_W=8:
  - bin=8'h80 → neg=1, bcd=12'h128;
  - bin=8'hFF → neg=1, bcd=12'h001;
  - bin=8'h7F → neg=0, bcd=12'h127.
- Throughput: back-to-back inputs with out_ready=1 → one result every BIN_W+2 cycles, no lost or duplicated results.

Source files
------------

// File: rtl/btobcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package btobcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int BCD_DIGIT_W = 4;

    // Smallest digit count whose decimal range covers 2**bin_w - 1.
    function automatic int min_digits(input int bin_w);
        longint unsigned max_v;
        longint unsigned pow10;
        int              d;
        max_v = (64'd1 << bin_w) - 64'd1;
        d     = 1;
        pow10 = 64'd10;
        while (pow10 <= max_v) begin
            d     = d + 1;
            pow10 = pow10 * 64'd10;
        end
        return d;
    endfunction

endpackage

// File: rtl/binary_to_bcd_seq_digit_adj.sv
// One BCD digit pre-shift correction: add 3 when the digit is 5 or more.
// Combinational; a legal digit (0..9) never overflows 4 bits after the add.
module bcd_digit_adj
    import btobcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_in,
    output logic [BCD_DIGIT_W-1:0] digit_out
);

    always_comb begin
        digit_out = digit_in;
        if (digit_in >= BCD_DIGIT_W'(5)) begin
            digit_out = digit_in + BCD_DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/binary_to_bcd_seq.sv
// Double-dabble binary-to-BCD, one bit per clock; result valid BIN_W cycles after accept,
// held in DONE until out_ready. BTOBCD_SIGNED_EN converts |bin| of a two's-complement input.
module binary_to_bcd_seq
    import btobcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [BIN_W-1:0]                bin,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0]   bcd,
    output logic                            neg
);

    localparam int ACC_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W);

    if (BIN_W < 2) begin : g_bad_width
        $error("binary_to_bcd_seq: BIN_W must be at least 2");
    end
    if (DIGITS < min_digits(BIN_W)) begin : g_bad_digits
        $error("binary_to_bcd_seq: DIGITS too small for BIN_W");
    end

    state_e             state_q, state_d;
    logic [BIN_W-1:0]   sr_q, sr_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   bcd_q, bcd_d;
    logic               neg_q, neg_d;
    logic               neg_pend_q, neg_pend_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;

    logic [ACC_W-1:0]   acc_adj;
    logic [ACC_W-1:0]   acc_shift;
    logic [BIN_W-1:0]   sr_shift;
    logic [BIN_W-1:0]   load_val;
    logic               load_neg;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (acc_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_out (acc_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // The adjusted top digit never reaches 8, so nothing is lost off the top.
    assign {acc_shift, sr_shift} = {acc_adj, sr_q} << 1;

`ifdef BTOBCD_SIGNED_EN
    // -2**(BIN_W-1) negates to itself, which read unsigned is the right magnitude.
    assign load_neg = bin[BIN_W-1];
    assign load_val = load_neg ? (~bin + BIN_W'(1)) : bin;
`else
    assign load_neg = 1'b0;
    assign load_val = bin;
`endif

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        bcd_d       = bcd_q;
        neg_d       = neg_q;
        neg_pend_d  = neg_pend_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid) begin
                    sr_d       = load_val;
                    acc_d      = '0;
                    cnt_d      = CNT_W'(BIN_W - 1);
                    neg_pend_d = load_neg;
                    in_ready_d = 1'b0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                acc_d = acc_shift;
                sr_d  = sr_shift;
                if (cnt_q == '0) begin
                    bcd_d       = acc_shift;
                    neg_d       = neg_pend_q;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            bcd_q       <= '0;
            neg_q       <= 1'b0;
            neg_pend_q  <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            neg_q       <= neg_d;
            neg_pend_q  <= neg_pend_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Masking with rst keeps a reset-cycle in_valid from looking like a handshake.
    assign in_ready  = in_ready_q & ~rst;
    assign out_valid = out_valid_q;
    assign bcd       = bcd_q;
    assign neg       = neg_q;

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Scoreboard bench: a 4-bit/2-digit and an 8-bit/3-digit converter share clk and rst.
module tb_binary_to_bcd_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid4, in_ready4, out_valid4, out_ready4, neg4;
    logic [3:0]  bin4;
    logic [7:0]  bcd4;
    logic        in_valid8, in_ready8, out_valid8, out_ready8, neg8;
    logic [7:0]  bin8;
    logic [11:0] bcd8;

    binary_to_bcd_seq #(.BIN_W(4), .DIGITS(2)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .bin(bin4),
        .out_valid(out_valid4), .out_ready(out_ready4), .bcd(bcd4), .neg(neg4)
    );

    binary_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .bin(bin8),
        .out_valid(out_valid8), .out_ready(out_ready8), .bcd(bcd8), .neg(neg8)
    );

    typedef struct {
        logic [11:0] bcd;
        logic        neg;
        int          acc_cyc;
    } exp_t;

    exp_t q4[$];
    exp_t q8[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   tput4 = 1'b0;
    bit   tput8 = 1'b0;

`ifdef BTOBCD_SIGNED_EN
    localparam logic [7:0] T4 [16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                                       8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
`else
    localparam logic [7:0] T4 [16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                                       8'h08, 8'h09, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic send4(input logic [3:0] v, input logic [7:0] eb, input logic en);
        int   w = 0;
        exp_t e;
        @(negedge clk);
        while (!in_ready4 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready4) begin
            n_chk++;
            n_fail++;
            $display("FAIL dut4_accept_timeout: in_ready=0 after %0d cycles, expected 1", w);
        end else begin
            e.bcd = {4'h0, eb};
            e.neg = en;
            e.acc_cyc = cyc + 1;
            in_valid4 = 1'b1;
            bin4 = v;
            q4.push_back(e);
            @(negedge clk);
            in_valid4 = 1'b0;
        end
    endtask

    task automatic send8(input logic [7:0] v, input logic [11:0] eb, input logic en);
        int   w = 0;
        exp_t e;
        @(negedge clk);
        while (!in_ready8 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready8) begin
            n_chk++;
            n_fail++;
            $display("FAIL dut8_accept_timeout: in_ready=0 after %0d cycles, expected 1", w);
        end else begin
            e.bcd = eb;
            e.neg = en;
            e.acc_cyc = cyc + 1;
            in_valid8 = 1'b1;
            bin8 = v;
            q8.push_back(e);
            @(negedge clk);
            in_valid8 = 1'b0;
        end
    endtask

    task automatic drain();
        int w = 0;
        while ((q4.size() != 0 || q8.size() != 0 || out_valid4 || out_valid8) && w < 300) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (w >= 300) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: %0d/%0d results outstanding, expected 0", q4.size(), q8.size());
        end
    endtask

    initial begin : mon4
        bit prev = 1'b0;
        int last = -1;
        forever begin
            @(negedge clk);
            #1;
            if (!tput4) last = -1;
            if (out_valid4) begin
                if (q4.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL dut4_spurious: out_valid=1 bcd=%0h, expected no result", bcd4);
                end else begin
                    if (!prev) begin
                        check("dut4_latency", cyc - q4[0].acc_cyc, 4);
                        if (tput4 && last >= 0) check("dut4_period", cyc - last, 6);
                        if (tput4) last = cyc;
                    end
                    check("dut4_bcd", {24'h0, bcd4}, {20'h0, q4[0].bcd});
                    check("dut4_neg", {31'h0, neg4}, {31'h0, q4[0].neg});
                    if (out_ready4) void'(q4.pop_front());
                end
            end
            prev = out_valid4;
        end
    end

    initial begin : mon8
        bit prev = 1'b0;
        int last = -1;
        forever begin
            @(negedge clk);
            #1;
            if (!tput8) last = -1;
            if (out_valid8) begin
                if (q8.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL dut8_spurious: out_valid=1 bcd=%0h, expected no result", bcd8);
                end else begin
                    if (!prev) begin
                        check("dut8_latency", cyc - q8[0].acc_cyc, 8);
                        if (tput8 && last >= 0) check("dut8_period", cyc - last, 10);
                        if (tput8) last = cyc;
                    end
                    check("dut8_bcd", {20'h0, bcd8}, {20'h0, q8[0].bcd});
                    check("dut8_neg", {31'h0, neg8}, {31'h0, q8[0].neg});
                    if (out_ready8) void'(q8.pop_front());
                end
            end
            prev = out_valid8;
        end
    end

    initial begin : stim
        int w;
        rst = 1'b1;
        in_valid4 = 1'b0; bin4 = '0; out_ready4 = 1'b1;
        in_valid8 = 1'b0; bin8 = '0; out_ready8 = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready8", {31'h0, in_ready8}, 0);
        check("rst_in_ready4", {31'h0, in_ready4}, 0);
        check("rst_out_valid8", {31'h0, out_valid8}, 0);
        check("rst_bcd8", {20'h0, bcd8}, 0);
        check("rst_neg8", {31'h0, neg8}, 0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("post_rst_in_ready8", {31'h0, in_ready8}, 1);
        check("post_rst_in_ready4", {31'h0, in_ready4}, 1);

        // Sweep 0..15 then wrap to 0, back to back.
        tput4 = 1'b1;
        for (int v = 0; v < 17; v++) begin
`ifdef BTOBCD_SIGNED_EN
            send4(4'(v), T4[v % 16], (v % 16) >= 8);
`else
            send4(4'(v), T4[v % 16], 1'b0);
`endif
        end
        drain();
        tput4 = 1'b0;

`ifdef BTOBCD_SIGNED_EN
        send8(8'h80, 12'h128, 1'b1);
        send8(8'hFF, 12'h001, 1'b1);
        send8(8'h7F, 12'h127, 1'b0);
`else
        send8(8'd255, 12'h255, 1'b0);
`endif
        send8(8'd0, 12'h000, 1'b0);
        send8(8'd100, 12'h100, 1'b0);
        drain();

        // Backpressure: hold the result, poke in_valid while held.
        out_ready8 = 1'b0;
        send8(8'd100, 12'h100, 1'b0);
        w = 0;
        while (!out_valid8 && w < 50) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("bp_out_valid8", {31'h0, out_valid8}, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            check("bp_in_ready8", {31'h0, in_ready8}, 0);
            in_valid8 = (i >= 2 && i < 5);
            bin8 = 8'd7;
        end
        in_valid8 = 1'b0;
        @(negedge clk);
        out_ready8 = 1'b1;
        drain();
        send8(8'd37, 12'h037, 1'b0);
        drain();

        // Reset during the third SHIFT cycle, with in_valid raised alongside.
        send8(8'd200, 12'h200, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        in_valid8 = 1'b1;
        bin8 = 8'd9;
        #1;
        check("rst_mid_in_ready8", {31'h0, in_ready8}, 0);
        @(negedge clk);
        rst = 1'b0;
        in_valid8 = 1'b0;
        q8.delete();
        #1;
        check("rst_mid_out_valid8", {31'h0, out_valid8}, 0);
        check("rst_mid_bcd8", {20'h0, bcd8}, 0);
        check("rst_mid_in_ready8_after", {31'h0, in_ready8}, 1);
        send8(8'd42, 12'h042, 1'b0);
        drain();

        tput8 = 1'b1;
        send8(8'd99, 12'h099, 1'b0);
        send8(8'd9, 12'h009, 1'b0);
`ifdef BTOBCD_SIGNED_EN
        send8(8'h80, 12'h128, 1'b1);
`else
        send8(8'h80, 12'h128, 1'b0);
`endif
        send8(8'd255 - 8'd155, 12'h100, 1'b0);
        drain();
        tput8 = 1'b0;

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
